fifo_n2w: RTL and testbench
===========================

Name: fifo_n2w

Overview:
- Byte-in, word-out FIFO that packs DATA_WIDTH-wide writes into 2*DATA_WIDTH-wide reads.
- Inverse width conversion of the team's wide-write/narrow-read FIFO. Sits where a byte-serial producer feeds a 16-bit consumer.
- Contains byte storage, write/read pointers, byte-occupancy count and full/empty status.
- The first byte written appears in the low half of the read word.

Parameters:
- ADDR_WIDTH, 3, log2 of depth in bytes. Must be ≥ 1. Depth 2**ADDR_WIDTH is always even.
- DATA_WIDTH, 8, width of one write entry. Read width is 2*DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- wr  input  1  push request: one byte per cycle.
- w_data  input  DATA_WIDTH  byte to push.
- rd  input  1  pop request: one word (two bytes) per cycle.
- r_data  output  2*DATA_WIDTH  current head word, {mem[r_ptr+1], mem[r_ptr]}.
- full  output  1  count == 2**ADDR_WIDTH.
- empty  output  1  count < 2, meaning no complete word is available.

Behaviour:
- State:
  - w_ptr [ADDR_WIDTH-1:0]
  - r_ptr [ADDR_WIDTH-1:0]; always even
  - count [ADDR_WIDTH:0]; bytes held
  - mem [0:2**ADDR_WIDTH-1] of DATA_WIDTH; not reset
- Reset (rst_n=0 at posedge): w_ptr=0, r_ptr=0, count=0. Therefore full=0 and empty=1 on the following cycle. Reset overrides any concurrent wr/rd.
- Accept rules:
  - wr_ok = wr & ~full
  - rd_ok = rd & ~empty
  - Both are evaluated against registered status at the start of the cycle.
- Write: on wr_ok, mem[w_ptr] <= w_data and w_ptr <= w_ptr+1, wrapping modulo depth.
- Read: on rd_ok, r_ptr <= r_ptr+2, wrapping modulo depth.
- Count update:
  - wr_ok only: +1
  - rd_ok only: -2
  - both: -1
  - neither: hold
- Status: full and empty are decoded combinationally from count (registered state), so they update one cycle after the causing edge.
- r_data:
  - Combinational from mem and r_ptr; zero latency.
  - Valid only while empty=0. Undefined (X allowed) after reset until two bytes have been written.
- Boundaries:
  - wr while full: dropped. No pointer, count or mem change, even if rd is asserted the same cycle.
  - rd while empty, including count==1: ignored. The lone byte is retained and pairs with the next write.
  - wr & rd at count==1: write only, count becomes 2.
  - wr & rd at count==depth: read only, count becomes depth-2.
  - Wrap: w_ptr wraps from depth-1 to 0. r_ptr wraps from depth-2 to 0. A word never straddles the wrap because r_ptr is even.
- There is no internal FSM beyond pointer and count registers. No combinational path from wr or rd to full or empty.

Optional Feature:
- Macro: FIFO_N2W_LEVEL_EN.
- Defined:
  - Extra output port `level` [ADDR_WIDTH:0] equal to count, the byte occupancy. Reset value 0.
  - Extra output port `half_word` (1 bit) = count[0], asserted while an unpaired byte is pending.
- Undefined: neither port exists. Behaviour is otherwise identical.

Decomposition:
- Package fifo_n2w_pkg:
  - Default ADDR_WIDTH and DATA_WIDTH localparams.
  - Typedef byte_t (DATA_WIDTH) and word_t (2*DATA_WIDTH).
- Sub-module fifo_n2w_ctrl:
  - Holds pointers, count, wr_ok/rd_ok gating and full/empty decode.
  - Top level holds the storage array and the r_data concatenation.

Test Plan:
- Reset then idle → full=0, empty=1, count 0. Assert rd for 3 cycles → no pointer change, empty stays 1.
- Write 0x11, then 0x22 → empty=0 the cycle after the second write; r_data=0x2211. rd one cycle → empty=1.
- Write 8 bytes 0x01..0x08 (depth 8) → full=1 after the 8th. 9th write 0xFF dropped. Four reads return 0x0201, 0x0403, 0x0605, 0x0807, then empty=1.
- Wrap: fill 6 bytes, read 3 words, then write 0xA0..0xA5 → pointers wrap. Reads return 0xA1A0, 0xA3A2, 0xA5A4.
- Simultaneous: at count==1 (byte 0x33 held), wr 0x44 with rd → read ignored; next cycle r_data=0x4433, empty=0. At full, wr with rd → word popped, byte dropped, count=6.
- Mid-operation reset: with 5 bytes held, pull rst_n low for one cycle while wr=1 → count=0, empty=1, write not taken. Subsequent writes 0x55, 0x66 give r_data=0x6655.

Source files
------------

// File: rtl/fifo_n2w_pkg.sv
// Shared defaults and types for the byte-in / word-out FIFO.
package fifo_n2w_pkg;

    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 8;

    typedef logic [DEF_DATA_WIDTH-1:0]   byte_t;
    typedef logic [2*DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/fifo_n2w_ctrl.sv
// Pointer, byte-count and status control for fifo_n2w.
// FIFO_N2W_LEVEL_EN exposes the byte count.
module fifo_n2w_ctrl
    import fifo_n2w_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
`ifdef FIFO_N2W_LEVEL_EN
    output logic [ADDR_WIDTH:0]   count,
`endif
    output logic                  wr_ok,
    output logic                  rd_ok,
    output logic [ADDR_WIDTH-1:0] w_ptr,
    output logic [ADDR_WIDTH-1:0] r_ptr,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] TWO   = (ADDR_WIDTH+1)'(2);

    logic [ADDR_WIDTH:0] cnt;
    logic [ADDR_WIDTH:0] cnt_nxt;

    assign full  = (cnt == DEPTH);
    assign empty = (cnt < TWO);
    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;

`ifdef FIFO_N2W_LEVEL_EN
    assign count = cnt;
`endif

    always_comb begin
        cnt_nxt = cnt;
        unique case ({wr_ok, rd_ok})
            2'b10:   cnt_nxt = cnt + (ADDR_WIDTH+1)'(1);
            2'b01:   cnt_nxt = cnt - TWO;
            2'b11:   cnt_nxt = cnt - (ADDR_WIDTH+1)'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // r_ptr stays even, so +2 wraps cleanly at depth-2 -> 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
            cnt   <= '0;
        end else begin
            if (wr_ok)
                w_ptr <= w_ptr + ADDR_WIDTH'(1);
            if (rd_ok)
                r_ptr <= r_ptr + ADDR_WIDTH'(2);
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/fifo_n2w.sv
// Byte-in, word-out FIFO; first byte written lands in the low half.
// FIFO_N2W_LEVEL_EN adds level and half_word outputs.
module fifo_n2w
    import fifo_n2w_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    rd,
`ifdef FIFO_N2W_LEVEL_EN
    output logic [ADDR_WIDTH:0]     level,
    output logic                    half_word,
`endif
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    full,
    output logic                    empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    fifo_n2w_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr),
        .rd    (rd),
`ifdef FIFO_N2W_LEVEL_EN
        .count (level),
`endif
        .wr_ok (wr_ok),
        .rd_ok (rd_ok),
        .w_ptr (w_ptr),
        .r_ptr (r_ptr),
        .full  (full),
        .empty (empty)
    );

`ifdef FIFO_N2W_LEVEL_EN
    assign half_word = level[0];
`endif

    // reset wins over a concurrent push, storage included
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok)
            mem[w_ptr] <= w_data;
    end

    assign r_data = {mem[r_ptr | ADDR_WIDTH'(1)], mem[r_ptr]};

endmodule

// File: tb/tb_fifo_n2w.sv
// Directed self-checking bench for fifo_n2w (default depth 8, 8-bit bytes).
`timescale 1ns/1ps
module tb_fifo_n2w;
    import fifo_n2w_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  wr;
    logic  rd;
    byte_t w_data;
    word_t r_data;
    logic  full;
    logic  empty;

    int total = 0;
    int bad   = 0;

    fifo_n2w dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (wr),
        .w_data (w_data),
        .rd     (rd),
`ifdef FIFO_N2W_LEVEL_EN
        .level     (),
        .half_word (),
`endif
        .r_data (r_data),
        .full   (full),
        .empty  (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic w, input byte_t d, input logic r);
        wr     = w;
        w_data = d;
        rd     = r;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic push(input byte_t d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic pop_chk(input string tag, input word_t exp);
        check(tag, {16'h0, r_data}, {16'h0, exp});
        check({tag, "_ne"}, {31'h0, empty}, 32'h0);
        step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        rst_n  = 1'b0;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = '0;
        step(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        check("rst_full", {31'h0, full}, 32'h0);
        check("rst_empty", {31'h0, empty}, 32'h1);

        for (int i = 0; i < 3; i++)
            step(1'b0, 8'h00, 1'b1);
        check("rd_empty", {31'h0, empty}, 32'h1);

        push(8'h11);
        check("one_byte_empty", {31'h0, empty}, 32'h1);
        push(8'h22);
        check("pair_empty", {31'h0, empty}, 32'h0);
        check("pair_data", {16'h0, r_data}, 32'h2211);
        step(1'b0, 8'h00, 1'b1);
        check("pair_pop_empty", {31'h0, empty}, 32'h1);

        for (int i = 1; i <= 8; i++) begin
            check($sformatf("fill_full%0d", i), {31'h0, full}, 32'h0);
            push(byte_t'(i));
        end
        check("full_set", {31'h0, full}, 32'h1);
        push(8'hFF);
        check("full_hold", {31'h0, full}, 32'h1);
        pop_chk("drain0", 16'h0201);
        check("drain_nfull", {31'h0, full}, 32'h0);
        pop_chk("drain1", 16'h0403);
        pop_chk("drain2", 16'h0605);
        pop_chk("drain3", 16'h0807);
        check("drain_empty", {31'h0, empty}, 32'h1);

        for (int i = 0; i < 6; i++)
            push(byte_t'(8'hB0 + i));
        pop_chk("pre0", 16'hB1B0);
        pop_chk("pre1", 16'hB3B2);
        pop_chk("pre2", 16'hB5B4);
        for (int i = 0; i < 6; i++)
            push(byte_t'(8'hA0 + i));
        pop_chk("wrap0", 16'hA1A0);
        pop_chk("wrap1", 16'hA3A2);
        pop_chk("wrap2", 16'hA5A4);
        check("wrap_empty", {31'h0, empty}, 32'h1);

        push(8'h33);
        step(1'b1, 8'h44, 1'b1);
        check("sim1_empty", {31'h0, empty}, 32'h0);
        check("sim1_data", {16'h0, r_data}, 32'h4433);
        for (int i = 0; i < 6; i++)
            push(byte_t'(8'h50 + i));
        check("sim_full", {31'h0, full}, 32'h1);
        check("sim_head", {16'h0, r_data}, 32'h4433);
        step(1'b1, 8'hEE, 1'b1);
        check("simf_full", {31'h0, full}, 32'h0);
        pop_chk("simf0", 16'h5150);
        pop_chk("simf1", 16'h5352);
        pop_chk("simf2", 16'h5554);
        check("simf_empty", {31'h0, empty}, 32'h1);

        for (int i = 0; i < 5; i++)
            push(byte_t'(8'hC0 + i));
        check("pre_rst_empty", {31'h0, empty}, 32'h0);
        rst_n = 1'b0;
        step(1'b1, 8'h99, 1'b0);
        rst_n = 1'b1;
        check("mrst_empty", {31'h0, empty}, 32'h1);
        check("mrst_full", {31'h0, full}, 32'h0);
        push(8'h55);
        check("mrst_one", {31'h0, empty}, 32'h1);
        push(8'h66);
        check("mrst_empty2", {31'h0, empty}, 32'h0);
        check("mrst_data", {16'h0, r_data}, 32'h6655);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
